led_shifter: RTL and testbench

- Parameterised "bouncing light" LED driver.
- A free-running prescaler divides the system clock by 2^CNTDIV_BITS.
- Each prescaler tick moves a single lit bit one position across a SHIFT_BITS-wide output, reversing direction at each end (ping-pong).
- Top-level block driving board LEDs directly; no handshakes, no other inputs.

---
 rtl/led_shifter.sv | 78 +++++++
 tb/tb_led_shifter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_shifter.sv
// Bouncing-light LED driver: a free-running prescaler paces a single lit bit
// that ping-pongs across the output vector.
module led_shifter #(
    parameter int unsigned SHIFT_BITS  = 4,
    parameter int unsigned CNTDIV_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [SHIFT_BITS-1:0] qbits
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [CNTDIV_BITS-1:0] cnt_q, cnt_d;
    logic                   tick;

    logic [SHIFT_BITS-1:0]  qbits_q, qbits_d;
    dir_e                   dir_q, dir_d;
    logic                   one_hot;

    always_comb begin
        cnt_d = cnt_q + CNTDIV_BITS'(1);
        tick  = &cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero and multi-hot patterns both fail this test and trigger a reload.
    assign one_hot = (qbits_q != '0) &&
                     ((qbits_q & (qbits_q - SHIFT_BITS'(1))) == '0);

    always_comb begin
        qbits_d = qbits_q;
        dir_d   = dir_q;
        if (tick) begin
            if (!one_hot) begin
                qbits_d = SHIFT_BITS'(1);
                dir_d   = DIR_UP;
            end else if (dir_q == DIR_UP) begin
                if (qbits_q[SHIFT_BITS-1]) begin
                    dir_d   = DIR_DOWN;
                    qbits_d = qbits_q >> 1;
                end else begin
                    qbits_d = qbits_q << 1;
                end
            end else begin
                if (qbits_q[0]) begin
                    dir_d   = DIR_UP;
                    qbits_d = qbits_q << 1;
                end else begin
                    qbits_d = qbits_q >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qbits_q <= SHIFT_BITS'(1);
            dir_q   <= DIR_UP;
        end else begin
            qbits_q <= qbits_d;
            dir_q   <= dir_d;
        end
    end

    assign qbits = qbits_q;

endmodule

// File: tb/tb_led_shifter.sv
// Directed bench for led_shifter: reset, rate, bounce, async reset, recovery
// and an 8-bit/3-bit parameter sweep.
module tb_led_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst8 = 1'b0;
    logic [3:0] qbits;
    logic [7:0] qbits8;

    int nvec = 0;
    int nerr = 0;

    // Expected pattern per tick index for each configuration.
    logic [3:0] exp4 [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
    logic [7:0] exp8 [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                              8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    always #5 clk = ~clk;

    led_shifter #(.SHIFT_BITS(4), .CNTDIV_BITS(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .qbits (qbits)
    );

    led_shifter #(.SHIFT_BITS(8), .CNTDIV_BITS(3)) dut8 (
        .clk   (clk),
        .rst   (rst8),
        .qbits (qbits8)
    );

    task automatic test_reset();
        rst  = 1'b0;
        rst8 = 1'b0;
        #3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (qbits !== 4'h1) begin
                nerr++;
                $display("FAIL reset_hold cyc=%0d qbits=%b expected=%b", i, qbits, 4'h1);
            end
            nvec++;
            if (dut.cnt_q !== 2'd0) begin
                nerr++;
                $display("FAIL reset_count cyc=%0d cnt=%0d expected=0", i, dut.cnt_q);
            end
        end
    endtask

    task automatic test_rate();
        logic [3:0] e;
        @(negedge clk) rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            e = exp4[(k / 4) % 6];
            nvec++;
            if (qbits !== e) begin
                nerr++;
                $display("FAIL rate edge=%0d qbits=%b expected=%b", k, qbits, e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] e;
        for (int k = 13; k <= 100; k++) begin
            @(posedge clk); #1;
            e = exp4[(k / 4) % 6];
            nvec++;
            if (qbits !== e) begin
                nerr++;
                $display("FAIL bounce edge=%0d qbits=%b expected=%b", k, qbits, e);
            end
            nvec++;
            if (!$onehot(qbits)) begin
                nerr++;
                $display("FAIL onehot edge=%0d qbits=%b expected one-hot", k, qbits);
            end
        end
    endtask

    task automatic test_async_reset();
        bit         found = 1'b0;
        logic [3:0] e;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (qbits === 4'h8) begin
                found = 1'b1;
                break;
            end
        end
        nvec++;
        if (!found) begin
            nerr++;
            $display("FAIL reach_msb qbits=%b expected=%b within 30 edges", qbits, 4'h8);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        nvec++;
        if (qbits !== 4'h1) begin
            nerr++;
            $display("FAIL async_clear qbits=%b expected=%b", qbits, 4'h1);
        end
        nvec++;
        if (dut.cnt_q !== 2'd0) begin
            nerr++;
            $display("FAIL async_count cnt=%0d expected=0", dut.cnt_q);
        end
        @(negedge clk) rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            e = (k < 4) ? 4'h1 : 4'h2;
            nvec++;
            if (qbits !== e) begin
                nerr++;
                $display("FAIL post_reset edge=%0d qbits=%b expected=%b", k, qbits, e);
            end
        end
    endtask

    // Entered 1ns after a tick edge, so the prescaler sits at 0.
    task automatic test_recovery();
        logic [3:0] e;
        force dut.qbits_q = 4'b0110;
        #2;
        release dut.qbits_q;
        #1;
        nvec++;
        if (qbits !== 4'b0110) begin
            nerr++;
            $display("FAIL corrupt_load qbits=%b expected=%b", qbits, 4'b0110);
        end
        for (int k = 5; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k < 8)       e = 4'b0110;
            else if (k < 12) e = 4'b0001;
            else if (k < 16) e = 4'b0010;
            else             e = 4'b0100;
            nvec++;
            if (qbits !== e) begin
                nerr++;
                $display("FAIL recovery edge=%0d qbits=%b expected=%b", k, qbits, e);
            end
        end
    endtask

    task automatic test_reset_on_tick();
        repeat (3) @(posedge clk);
        @(posedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if (qbits !== 4'h1) begin
            nerr++;
            $display("FAIL reset_on_tick qbits=%b expected=%b", qbits, 4'h1);
        end
        nvec++;
        if (dut.cnt_q !== 2'd0) begin
            nerr++;
            $display("FAIL reset_on_tick_cnt cnt=%0d expected=0", dut.cnt_q);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] e;
        nvec++;
        if (qbits8 !== 8'h01) begin
            nerr++;
            $display("FAIL sweep_reset qbits8=%h expected=%h", qbits8, 8'h01);
        end
        @(negedge clk) rst8 = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            @(posedge clk); #1;
            e = exp8[(k / 8) % 14];
            nvec++;
            if (qbits8 !== e) begin
                nerr++;
                $display("FAIL sweep edge=%0d qbits8=%h expected=%h", k, qbits8, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_bounce();
        test_async_reset();
        test_recovery();
        test_reset_on_tick();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
